pll_bringup_sequencer: RTL

- Sequences bring-up of the ring-oscillator PLL on the reference-oscillator domain: PLL reset, enable, settle, lock measurement, output-clock handoff.
- Captures the divider, DCO and trim configuration at start and drives it to the PLL as stable registered values.
- Drives clk_sel to the downstream glitch-free clock mux.
- Monitors loss of lock and falls back to the oscillator clock when lock is lost.

---
 rtl/pll_bringup_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pll_bringup_sequencer.sv
// pll_bringup_sequencer: reset/enable/settle/measure/lock sequencing for the
// ring-oscillator PLL, with loss-of-lock fallback to the oscillator clock.
module pll_bringup_sequencer #(
  parameter int RST_CYCLES      = 8,
  parameter int SETTLE_CYCLES   = 64,
  parameter int WIN_LOG2        = 4,
  parameter int LOCK_TOL        = 1,
  parameter int LOCK_WINDOWS    = 4,
  parameter int LOSS_WINDOWS    = 2,
  parameter int TIMEOUT_WINDOWS = 64
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [4:0]  cfg_div,
  input  logic        cfg_dco,
  input  logic [25:0] cfg_ext_trim,
  input  logic        fb_tick,
  output logic        pll_resetb,
  output logic        pll_enable,
  output logic [4:0]  pll_div,
  output logic        pll_dco,
  output logic [25:0] pll_ext_trim,
  output logic        clk_sel,
  output logic        locked,
  output logic        busy,
  output logic        fail
);

  localparam int DMAX = (SETTLE_CYCLES > RST_CYCLES) ?
                        SETTLE_CYCLES : RST_CYCLES;
  localparam int DW = $clog2(DMAX + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int BW = $clog2(LOSS_WINDOWS + 1);
  localparam int TW = $clog2(TIMEOUT_WINDOWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SETTLE, S_MEASURE, S_LOCKED, S_FAIL
  } state_t;

  state_t              state;
  logic [DW-1:0]       dly;
  logic [WIN_LOG2-1:0] win;
  logic [5:0]          tcnt;
  logic [GW-1:0]       good_run;
  logic [BW-1:0]       bad_run;
  logic [TW-1:0]       total;

  logic [5:0] tcnt_nx;
  logic [6:0] cnt_w;
  logic [6:0] div_w;
  logic       win_end;
  logic       win_good;
  logic       monitor;

  // count includes a tick landing on the window's last cycle
  assign tcnt_nx  = (fb_tick && tcnt != 6'd63) ? tcnt + 6'd1 : tcnt;
  assign cnt_w    = {1'b0, tcnt_nx};
  assign div_w    = {2'b00, pll_div};
  assign win_end  = (win == '1);
  assign win_good = (cnt_w <= div_w + 7'(LOCK_TOL)) &&
                    (div_w <= cnt_w + 7'(LOCK_TOL));
  assign monitor  = (state == S_MEASURE) ||
                    (state == S_LOCKED && !pll_dco);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state        <= S_IDLE;
      dly          <= '0;
      win          <= '0;
      tcnt         <= '0;
      good_run     <= '0;
      bad_run      <= '0;
      total        <= '0;
      pll_resetb   <= 1'b0;
      pll_enable   <= 1'b0;
      pll_div      <= '0;
      pll_dco      <= 1'b0;
      pll_ext_trim <= '0;
      clk_sel      <= 1'b0;
      locked       <= 1'b0;
      busy         <= 1'b0;
      fail         <= 1'b0;
    end else begin
      if (monitor) begin
        win  <= win + WIN_LOG2'(1);
        tcnt <= win_end ? '0 : tcnt_nx;
      end
      if (state != S_IDLE && cfg_stop) begin
        state      <= S_IDLE;
        pll_resetb <= 1'b0;
        pll_enable <= 1'b0;
        clk_sel    <= 1'b0;
        locked     <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_FAIL: begin
            if (cfg_start && !cfg_stop) begin
              pll_div      <= cfg_div;
              pll_dco      <= cfg_dco;
              pll_ext_trim <= cfg_ext_trim;
              pll_resetb   <= 1'b0;
              pll_enable   <= 1'b0;
              fail         <= 1'b0;
              busy         <= 1'b1;
              dly          <= '0;
              state        <= S_RESET;
            end
          end
          S_RESET: begin
            if (dly == DW'(RST_CYCLES - 1)) begin
              dly        <= '0;
              pll_resetb <= 1'b1;
              pll_enable <= 1'b1;
              state      <= S_SETTLE;
            end else begin
              dly <= dly + DW'(1);
            end
          end
          S_SETTLE: begin
            if (dly == DW'(SETTLE_CYCLES - 1)) begin
              dly <= '0;
              if (pll_dco) begin
                state   <= S_LOCKED;
                locked  <= 1'b1;
                clk_sel <= 1'b1;
              end else if (pll_div == '0) begin
                state      <= S_FAIL;
                fail       <= 1'b1;
                busy       <= 1'b0;
                pll_enable <= 1'b0;
                pll_resetb <= 1'b0;
                clk_sel    <= 1'b0;
              end else begin
                state    <= S_MEASURE;
                win      <= '0;
                tcnt     <= '0;
                good_run <= '0;
                total    <= '0;
              end
            end else begin
              dly <= dly + DW'(1);
            end
          end
          S_MEASURE: begin
            if (win_end) begin
              if (win_good && good_run == GW'(LOCK_WINDOWS - 1)) begin
                state   <= S_LOCKED;
                bad_run <= '0;
                locked  <= 1'b1;
                clk_sel <= 1'b1;
              end else if (total == TW'(TIMEOUT_WINDOWS - 1)) begin
                state      <= S_FAIL;
                fail       <= 1'b1;
                busy       <= 1'b0;
                pll_enable <= 1'b0;
                pll_resetb <= 1'b0;
                clk_sel    <= 1'b0;
              end else begin
                total    <= total + TW'(1);
                good_run <= win_good ? good_run + GW'(1) : '0;
              end
            end
          end
          S_LOCKED: begin
            if (monitor && win_end) begin
              if (win_good) begin
                bad_run <= '0;
              end else if (bad_run == BW'(LOSS_WINDOWS - 1)) begin
                state    <= S_MEASURE;
                locked   <= 1'b0;
                clk_sel  <= 1'b0;
                bad_run  <= '0;
                good_run <= '0;
                total    <= '0;
              end else begin
                bad_run <= bad_run + BW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
